// File: rtl/wh_port_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wh_port_sched_pkg                                               |
// | Brief    : Shared flit encodings, FSM states and sizing helpers.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package wh_port_sched_pkg;

    typedef enum logic [2:0] {
        FT_HEADER = 3'b001,
        FT_BODY   = 3'b010,
        FT_TAIL   = 3'b100
    } flit_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    localparam int DEF_LEN_W = 12;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wh_port_sched_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_pick                                                         |
// | Brief    : Combinational round-robin search starting just after ptr.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rr_pick
    import wh_port_sched_pkg::*;
#(
    parameter int N_IN  = 5,
    parameter int PTR_W = idx_width(N_IN)
) (
    input  logic [N_IN-1:0]  qual,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_IN-1:0]  win,
    output logic             valid
);

    int j;

    always_comb begin
        win   = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = 1; k <= N_IN; k++) begin
            j = (int'(ptr) + k) % N_IN;
            if (!valid && qual[j]) begin
                win[j] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wh_port_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wh_port_sched                                                   |
// | Brief    : Wormhole output-port scheduler; define WH_SCHED_WATCHDOG_EN to  |
// |            add a stall watchdog that aborts a stuck packet.                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module wh_port_sched
    import wh_port_sched_pkg::*;
#(
    parameter int N_IN  = 5,
    parameter int LEN_W = DEF_LEN_W,
    parameter int TMO_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN-1:0]         req,
    input  logic [3*N_IN-1:0]       flit_type,
    input  logic [LEN_W*N_IN-1:0]   length,
    input  logic                    dcts,
    output logic [N_IN-1:0]         grant,
    output logic [N_IN-1:0]         sel,
    output logic                    busy,
    output logic                    err
);

    localparam int               PTR_W   = idx_width(N_IN);
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_IN - 1);

    if (TMO_W < 2) begin : g_tmo_check
        $error("wh_port_sched: TMO_W must be at least 2");
    end

    logic [2:0]       ftype [N_IN];
    logic [LEN_W-1:0] len_a [N_IN];
    logic [N_IN-1:0]  qual;
    logic [N_IN-1:0]  win_oh;
    logic             win_valid;
    logic [PTR_W-1:0] win_idx;

    state_t           state, state_n;
    logic [PTR_W-1:0] owner, owner_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [N_IN-1:0]  grant_n, sel_n;
    logic             busy_n, err_n;

`ifdef WH_SCHED_WATCHDOG_EN
    // Abort on the stall that would make the counter all-ones.
    localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    logic [TMO_W-1:0] wd, wd_n;
`endif

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        assign ftype[i] = flit_type[3*i +: 3];
        assign len_a[i] = length[LEN_W*i +: LEN_W];
        assign qual[i]  = req[i] && (ftype[i] == FT_HEADER);
    end

    rr_pick #(
        .N_IN  (N_IN),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .qual  (qual),
        .ptr   (ptr),
        .win   (win_oh),
        .valid (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (win_oh[i]) win_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            owner <= '0;
            ptr   <= PTR_RST;
            cnt   <= '0;
            grant <= '0;
            sel   <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
`ifdef WH_SCHED_WATCHDOG_EN
            wd    <= '0;
`endif
        end else begin
            state <= state_n;
            owner <= owner_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            grant <= grant_n;
            sel   <= sel_n;
            busy  <= busy_n;
            err   <= err_n;
`ifdef WH_SCHED_WATCHDOG_EN
            wd    <= wd_n;
`endif
        end
    end

    // sel/busy stay up through the releasing cycle and drop in the IDLE cycle after.
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        cnt_n   = cnt;
        grant_n = '0;
        sel_n   = sel;
        busy_n  = busy;
        err_n   = 1'b0;
`ifdef WH_SCHED_WATCHDOG_EN
        wd_n    = '0;
`endif
        case (state)
            ST_IDLE: begin
                sel_n  = '0;
                busy_n = 1'b0;
                if (dcts && win_valid) begin
                    grant_n = win_oh;
                    sel_n   = win_oh;
                    busy_n  = 1'b1;
                    owner_n = win_idx;
                    if (len_a[win_idx] <= LEN_W'(1)) begin
                        ptr_n = win_idx;
                        cnt_n = '0;
                    end else begin
                        state_n = ST_XFER;
                        cnt_n   = len_a[win_idx] - 1'b1;
                    end
                end
            end
            ST_XFER: begin
                if (req[owner] && (ftype[owner] == FT_HEADER)) begin
                    state_n = ST_IDLE;
                    ptr_n   = owner;
                    err_n   = 1'b1;
                end else if (dcts && req[owner]) begin
                    grant_n = sel;
                    cnt_n   = cnt - 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        state_n = ST_IDLE;
                        ptr_n   = owner;
                    end else if (ftype[owner] == FT_TAIL) begin
                        state_n = ST_IDLE;
                        ptr_n   = owner;
                        err_n   = 1'b1;
                    end
                end else begin
`ifdef WH_SCHED_WATCHDOG_EN
                    if (wd == WD_LAST) begin
                        state_n = ST_IDLE;
                        ptr_n   = owner;
                        err_n   = 1'b1;
                    end else begin
                        wd_n = wd + 1'b1;
                    end
`endif
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wh_port_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wh_port_sched                                                |
// | Brief    : Directed scenarios plus randomized traffic against a packet     |
// |            level reference model of the output-port scheduler.            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_wh_port_sched;

    localparam int         N   = 5;
    localparam int         LW  = 12;
    localparam int         TW  = 4;
    localparam logic [2:0] HDR = 3'b001;
    localparam logic [2:0] BDY = 3'b010;
    localparam logic [2:0] TL  = 3'b100;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [3*N-1:0]  flit_type;
    logic [LW*N-1:0] length;
    logic            dcts;
    logic [N-1:0]    grant;
    logic [N-1:0]    sel;
    logic            busy;
    logic            err;

    int n_tests = 0;
    int n_fail  = 0;

    wh_port_sched #(
        .N_IN  (N),
        .LEN_W (LW),
        .TMO_W (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .flit_type (flit_type),
        .length    (length),
        .dcts      (dcts),
        .grant     (grant),
        .sel       (sel),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req       = '0;
        flit_type = '0;
        length    = '0;
        dcts      = 1'b0;
    endtask

    task automatic set_in(input int i, input logic r, input logic [2:0] t, input int len);
        req[i]               = r;
        flit_type[3*i +: 3]  = t;
        length[LW*i +: LW]   = LW'(len);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        #1;
        n_tests++; if (grant !== 5'b0) begin n_fail++; $display("FAIL reset_grant got %b want %b", grant, 5'b0); end
        n_tests++; if (sel !== 5'b0) begin n_fail++; $display("FAIL reset_sel got %b want %b", sel, 5'b0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        tick();
        rst = 1'b1;
        set_in(0, 1'b1, BDY, 3);
        dcts = 1'b1;
        tick();
        n_tests++; if (grant !== 5'b0) begin n_fail++; $display("FAIL idle_body_nogrant got %b want %b", grant, 5'b0); end
        clear_inputs();
    endtask

    task automatic test_rr_priority();
        do_reset();
        set_in(1, 1'b1, HDR, 2);
        set_in(3, 1'b1, HDR, 3);
        dcts = 1'b0;
        tick();
        n_tests++; if ({grant, busy} !== 6'b0) begin n_fail++; $display("FAIL idle_dcts0 got %b want %b", {grant, busy}, 6'b0); end
        dcts = 1'b1;
        tick();
        n_tests++; if (grant !== 5'b00010) begin n_fail++; $display("FAIL rr_first grant got %b want %b", grant, 5'b00010); end
        n_tests++; if (sel !== 5'b00010) begin n_fail++; $display("FAIL rr_first sel got %b want %b", sel, 5'b00010); end
        set_in(1, 1'b1, TL, 0);
        tick();
        n_tests++; if (grant !== 5'b00010) begin n_fail++; $display("FAIL rr_tail grant got %b want %b", grant, 5'b00010); end
        set_in(1, 1'b0, BDY, 0);
        set_in(0, 1'b1, HDR, 2);
        tick();
        n_tests++; if (grant !== 5'b01000) begin n_fail++; $display("FAIL rr_next grant got %b want %b", grant, 5'b01000); end
        clear_inputs();
    endtask

    task automatic test_len4_stall();
        int dseq [5];
        int pulses;
        dseq   = '{1, 0, 1, 1, 1};
        pulses = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            dcts = (dseq[k] != 0);
            if (k == 0) set_in(2, 1'b1, HDR, 4);
            else        set_in(2, 1'b1, (k == 4) ? TL : BDY, 4);
            tick();
            n_tests++; if (grant !== (dcts ? 5'b00100 : 5'b00000)) begin n_fail++; $display("FAIL len4_grant[%0d] got %b dcts %b", k, grant, dcts); end
            n_tests++; if (sel !== 5'b00100) begin n_fail++; $display("FAIL len4_sel[%0d] got %b want %b", k, sel, 5'b00100); end
            if (grant[2]) pulses++;
        end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL len4_err got %b want 0", err); end
        set_in(2, 1'b0, BDY, 0);
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len4_busy_drop got %b want 0", busy); end
        n_tests++; if (pulses !== 4) begin n_fail++; $display("FAIL len4_pulses got %0d want 4", pulses); end
        clear_inputs();
    endtask

    task automatic test_single_flit();
        do_reset();
        dcts = 1'b1;
        set_in(0, 1'b1, HDR, 1);
        tick();
        n_tests++; if ({grant, busy} !== 6'b000011) begin n_fail++; $display("FAIL single1_grant_busy got %b want %b", {grant, busy}, 6'b000011); end
        set_in(0, 1'b0, BDY, 0);
        tick();
        n_tests++; if ({grant, busy} !== 6'b0) begin n_fail++; $display("FAIL single1_release got %b want %b", {grant, busy}, 6'b0); end
        set_in(4, 1'b1, HDR, 0);
        tick();
        n_tests++; if (grant !== 5'b10000) begin n_fail++; $display("FAIL single0_grant got %b want %b", grant, 5'b10000); end
        set_in(4, 1'b0, BDY, 0);
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single0_busy got %b want 0", busy); end
        clear_inputs();
    endtask

    task automatic test_protocol_err();
        do_reset();
        dcts = 1'b1;
        set_in(1, 1'b1, HDR, 4);
        tick();
        set_in(1, 1'b1, TL, 0);
        tick();
        n_tests++; if ({grant, err} !== 6'b000101) begin n_fail++; $display("FAIL early_tail got %b want %b", {grant, err}, 6'b000101); end
        set_in(1, 1'b0, BDY, 0);
        tick();
        n_tests++; if ({busy, err} !== 2'b00) begin n_fail++; $display("FAIL early_tail_release got %b want 00", {busy, err}); end

        set_in(3, 1'b1, HDR, 5);
        tick();
        set_in(3, 1'b1, BDY, 0);
        tick();
        n_tests++; if (grant !== 5'b01000) begin n_fail++; $display("FAIL hdr_body grant got %b want %b", grant, 5'b01000); end
        set_in(3, 1'b1, HDR, 5);
        tick();
        n_tests++; if ({grant, err} !== 6'b000001) begin n_fail++; $display("FAIL mid_header got %b want %b", {grant, err}, 6'b000001); end
        set_in(3, 1'b0, BDY, 0);
        tick();
        n_tests++; if ({busy, err} !== 2'b00) begin n_fail++; $display("FAIL mid_header_release got %b want 00", {busy, err}); end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        dcts = 1'b1;
        set_in(2, 1'b1, HDR, 6);
        tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy got %b want 1", busy); end
        set_in(2, 1'b1, BDY, 6);
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if ({grant, sel, busy, err} !== 12'b0) begin n_fail++; $display("FAIL arst_clear got %b want 0", {grant, sel, busy, err}); end
        tick();
        set_in(2, 1'b1, HDR, 6);
        set_in(0, 1'b1, HDR, 2);
        rst = 1'b1;
        tick();
        n_tests++; if ({grant, err} !== 6'b000010) begin n_fail++; $display("FAIL arst_ptr got %b want %b", {grant, err}, 6'b000010); end
        clear_inputs();
    endtask

    task automatic test_watchdog();
        do_reset();
        dcts = 1'b1;
        set_in(1, 1'b1, HDR, 3);
        tick();
        set_in(1, 1'b0, BDY, 0);
`ifdef WH_SCHED_WATCHDOG_EN
        for (int k = 1; k <= 15; k++) begin
            tick();
            n_tests++; if (err !== (k == 15)) begin n_fail++; $display("FAIL wd_err[%0d] got %b want %b", k, err, (k == 15)); end
        end
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wd_release busy got %b want 0", busy); end
`else
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_tests++; if ({busy, err} !== 2'b10) begin n_fail++; $display("FAIL nowd_hold[%0d] got %b want 10", k, {busy, err}); end
        end
        set_in(1, 1'b1, BDY, 0);
        tick();
        n_tests++; if (grant !== 5'b00010) begin n_fail++; $display("FAIL nowd_resume got %b want %b", grant, 5'b00010); end
`endif
        clear_inputs();
    endtask

    task automatic test_random();
        int           m_own;
        int           m_rem;
        int           m_last;
        int           r;
        int           idx;
        bit           done;
        logic [2:0]   t;
        logic [N-1:0] e_grant;
        logic [N-1:0] e_sel;
        logic         e_busy;
        logic         e_err;
`ifdef WH_SCHED_WATCHDOG_EN
        int           m_stall;
        m_stall = 0;
`endif
        do_reset();
        m_own  = -1;
        m_rem  = 0;
        m_last = N - 1;
        for (int c = 0; c < 400; c++) begin
            dcts = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 9);
                t = (r < 3) ? HDR : ((r < 8) ? BDY : TL);
                set_in(i, ($urandom_range(0, 3) != 0), t, $urandom_range(0, 6));
            end
            e_grant = '0;
            e_err   = 1'b0;
            done    = 1'b0;
            if (m_own < 0) begin
                e_sel  = '0;
                e_busy = 1'b0;
                if (dcts) begin
                    for (int k = 1; k <= N; k++) begin
                        idx = (m_last + k) % N;
                        if (!e_busy && req[idx] && flit_type[3*idx +: 3] == HDR) begin
                            e_grant[idx] = 1'b1;
                            e_sel[idx]   = 1'b1;
                            e_busy       = 1'b1;
                            if (length[LW*idx +: LW] <= 1) begin
                                m_last = idx;
                            end else begin
                                m_own = idx;
                                m_rem = int'(length[LW*idx +: LW]) - 1;
`ifdef WH_SCHED_WATCHDOG_EN
                                m_stall = 0;
`endif
                            end
                        end
                    end
                end
            end else begin
                e_sel        = '0;
                e_sel[m_own] = 1'b1;
                e_busy       = 1'b1;
                t            = flit_type[3*m_own +: 3];
                if (req[m_own] && t == HDR) begin
                    e_err = 1'b1;
                    done  = 1'b1;
                end else if (dcts && req[m_own]) begin
                    e_grant = e_sel;
                    m_rem   = m_rem - 1;
`ifdef WH_SCHED_WATCHDOG_EN
                    m_stall = 0;
`endif
                    if (m_rem == 0) begin
                        done = 1'b1;
                    end else if (t == TL) begin
                        e_err = 1'b1;
                        done  = 1'b1;
                    end
                end else begin
`ifdef WH_SCHED_WATCHDOG_EN
                    m_stall = m_stall + 1;
                    if (m_stall == (1 << TW) - 1) begin
                        e_err = 1'b1;
                        done  = 1'b1;
                    end
`endif
                end
                if (done) begin
                    m_last = m_own;
                    m_own  = -1;
                end
            end
            tick();
            n_tests++; if (grant !== e_grant) begin n_fail++; $display("FAIL rand_grant[%0d] got %b want %b", c, grant, e_grant); end
            n_tests++; if (sel !== e_sel) begin n_fail++; $display("FAIL rand_sel[%0d] got %b want %b", c, sel, e_sel); end
            n_tests++; if ({busy, err} !== {e_busy, e_err}) begin n_fail++; $display("FAIL rand_busy_err[%0d] got %b want %b", c, {busy, err}, {e_busy, e_err}); end
            n_tests++; if ($countones(grant) > 1 || (grant & ~sel) != '0) begin n_fail++; $display("FAIL rand_onehot_subset[%0d] got grant %b sel %b", c, grant, sel); end
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        test_reset();
        test_rr_priority();
        test_len4_stall();
        test_single_flit();
        test_protocol_err();
        test_async_reset();
        test_watchdog();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wh_port_sched.md
WH_PORT_SCHED -- requirements
Module: wh_port_sched

Interface
REQ-001 The block SHALL have parameter N_IN, default 5, meaning the number of input ports competing for one output port (index 0=L, 1=N, 2=E, 3=W, 4=S).
REQ-002 The block SHALL have parameter LEN_W, default 12, meaning the width of the packet length field.
REQ-003 The block SHALL have parameter TMO_W, default 8, meaning the width of the stall watchdog counter.
REQ-004 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port rst: input, 1 bit, asynchronous, active-low reset.
REQ-006 Port req: input, N_IN bits, per-input flow-control ready (input FIFO non-empty and routed to this output).
REQ-007 Port flit_type: input, 3*N_IN bits, per-input head-flit type, one-hot: 001 header, 010 body, 100 tail.
REQ-008 Port length: input, LEN_W*N_IN bits, per-input total packet length in flits, header included, valid with a header.
REQ-009 Port dcts: input, 1 bit, downstream clear-to-send for this output.
REQ-010 Port grant: output, N_IN bits, registered one-hot FIFO read enable, one flit per asserted cycle.
REQ-011 Port sel: output, N_IN bits, registered one-hot crossbar select, held for the whole packet.
REQ-012 Port busy: output, 1 bit, high while a packet owns the output.
REQ-013 Port err: output, 1 bit, one-cycle pulse on a protocol violation or watchdog abort.

Function
REQ-014 States SHALL be IDLE and XFER, with registered owner index, round-robin pointer ptr and flit counter cnt (LEN_W bits).
REQ-015 IDLE qualifying inputs: i with req[i]=1 and flit_type[i]=header; the winner SHALL be the first qualifying i searching ptr+1, ptr+2, ... modulo N_IN.
REQ-016 In IDLE with dcts=1 and a winner w, the next cycle SHALL show grant=onehot(w), sel=onehot(w), busy=1, owner=w, cnt=length[w]-1, and state XFER.
REQ-017 If length[w] is 0 or 1, the packet SHALL be single-flit: grant pulses once, state returns to IDLE, ptr=w, and busy/sel clear one cycle later.
REQ-018 In XFER, a transfer SHALL occur in any cycle with dcts=1 and req[owner]=1; grant=onehot(owner) next cycle, else grant=0.
REQ-019 Each XFER transfer SHALL decrement cnt; the transfer that brings cnt to 0 SHALL move to IDLE, set ptr=owner, and clear sel/busy the following cycle.
REQ-020 If a tail flit transfers with cnt>1, the block SHALL release as in REQ-019 and pulse err.
REQ-021 If a header appears at the owner in XFER, the block SHALL NOT transfer it, SHALL release to IDLE and SHALL pulse err.
REQ-022 In XFER, requests from non-owners SHALL be ignored; dcts=0 SHALL stall without losing cnt.
REQ-023 In IDLE, dcts=0 SHALL suppress all grants; ptr SHALL change only on packet completion.
REQ-024 grant SHALL never have more than one bit set, and SHALL always be a subset of sel.

Reset
REQ-025 On rst low, regardless of clk: state=IDLE, grant=0, sel=0, busy=0, err=0, cnt=0, owner=0, ptr=N_IN-1 (so input 0 has first priority).
REQ-026 A reset asserted mid-packet SHALL abandon the packet with no further grants and no err pulse.

Configuration
REQ-027 Macro WH_SCHED_WATCHDOG_EN: when defined, a TMO_W-bit counter SHALL count consecutive XFER cycles without a transfer, clear on every transfer, and on reaching all-ones force IDLE, set ptr=owner, and pulse err.
REQ-028 When WH_SCHED_WATCHDOG_EN is undefined, no watchdog logic SHALL exist, and XFER SHALL stall indefinitely.

Structure
REQ-029 Flit-type encodings (header/body/tail) and the state encoding SHALL live in the shared parameters include; the length field width SHALL default from it.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_pick (inputs: qualify vector, ptr; output: one-hot winner, valid).

Verification
REQ-031 Headers on inputs 1 and 3, ptr=4, dcts=1 -> grant=00010 next cycle; after the packet, the next header goes to input 3.
REQ-032 Input 2 header with length=4, dcts toggled 1,0,1,1,1 -> exactly four grant pulses on bit 2; sel=00100 throughout; busy drops after the 4th.
REQ-033 Single-flit packet length=1 on input 0 -> one grant pulse, busy high exactly one cycle.
REQ-034 Tail on the owner with cnt=3 -> release and err pulse; a header on the owner mid-packet -> no grant, release, err pulse.
REQ-035 rst low during XFER with cnt=5 -> grant/sel/busy zero immediately (asynchronous), ptr=N_IN-1 after release.
REQ-036 With WH_SCHED_WATCHDOG_EN, TMO_W=4, the owner stalled by req=0 for 15 cycles -> IDLE plus err; without the macro, the block stays in XFER.
